// File: rtl/uart_bus_master_pkg.sv
// Shared definitions for the UART-driven debug bus master.
// Holds the command opcodes, response status codes, the master FSM state
// type and the bit offsets of the packed PicoRV32 memory bus vectors.
// mpack and munpack both use the same offsets.
package uart_bus_master_pkg;

  // Command opcodes received from the host
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'

  // Response status codes sent back to the host
  localparam logic [7:0] ST_ACK = 8'h06;
  localparam logic [7:0] ST_NAK = 8'h15;

  // Forward bus vector: {wdata[31:0], wstrb[3:0], valid, addr[31:0]}
  localparam int unsigned FWD_W         = 69;
  localparam int unsigned FWD_ADDR_LSB  = 0;
  localparam int unsigned FWD_VALID_BIT = 32;
  localparam int unsigned FWD_WSTRB_LSB = 33;
  localparam int unsigned FWD_WDATA_LSB = 37;

  // Return bus vector: {ready, rdata[31:0]}
  localparam int unsigned RET_W         = 33;
  localparam int unsigned RET_RDATA_LSB = 0;
  localparam int unsigned RET_READY_BIT = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

endpackage

// File: rtl/uart_bus_master_mpack.sv
// mpack: packs the initiator-side bus fields into mem_packed_fwd and splits
// mem_packed_ret into ready/rdata. Purely combinational.
// Ports:
//   addr, valid, wstrb, wdata : forward fields from the initiator
//   mem_packed_fwd            : packed forward bus vector
//   mem_packed_ret            : packed return bus vector
//   ready, rdata              : unpacked return fields
module mpack
  import uart_bus_master_pkg::*;
(
  input  logic [31:0]      addr,
  input  logic             valid,
  input  logic [3:0]       wstrb,
  input  logic [31:0]      wdata,
  output logic [FWD_W-1:0] mem_packed_fwd,
  input  logic [RET_W-1:0] mem_packed_ret,
  output logic             ready,
  output logic [31:0]      rdata
);

  always_comb begin
    mem_packed_fwd                       = '0;
    mem_packed_fwd[FWD_ADDR_LSB +: 32]   = addr;
    mem_packed_fwd[FWD_VALID_BIT]        = valid;
    mem_packed_fwd[FWD_WSTRB_LSB +: 4]   = wstrb;
    mem_packed_fwd[FWD_WDATA_LSB +: 32]  = wdata;
  end

  assign ready = mem_packed_ret[RET_READY_BIT];
  assign rdata = mem_packed_ret[RET_RDATA_LSB +: 32];

endmodule

// File: rtl/uart_bus_master.sv
// uart_bus_master: debug bus initiator driven by a byte-stream protocol.
// Read  frame: 'R' a3 a2 a1 a0            -> 06 d3 d2 d1 d0 | 15 FF FF FF FF
// Write frame: 'W' a3 a2 a1 a0 d3 d2 d1 d0 -> 06 | 15
// Unknown bytes received while idle are discarded silently.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   rx_tdata/tvalid/tready : command byte stream from uart_rx
//   tx_tdata/tvalid/tready : response byte stream to uart_tx
//   mem_packed_fwd     : {wdata, wstrb, valid, addr} to the bus decoder
//   mem_packed_ret     : {ready, rdata} from the bus decoder
//   busy               : a command is in progress
// Every output comes straight from a flop.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_tdata,
  input  logic             rx_tvalid,
  output logic             rx_tready,
  output logic [7:0]       tx_tdata,
  output logic             tx_tvalid,
  input  logic             tx_tready,
  output logic [FWD_W-1:0] mem_packed_fwd,
  input  logic [RET_W-1:0] mem_packed_ret,
  output logic             busy
);

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        valid_q, valid_d;
  logic [15:0] timer_q, timer_d;
  logic [31:0] shift_q, shift_d;
  logic [2:0]  rem_q, rem_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        rx_ready_q, rx_ready_d;
  logic        busy_q, busy_d;

  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        rx_fire;
  logic        tx_fire;
  logic [15:0] timer_inc;

  assign rx_fire   = rx_tvalid && rx_ready_q;
  assign tx_fire   = tx_valid_q && tx_tready;
  assign timer_inc = timer_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      valid_q    <= 1'b0;
      timer_q    <= '0;
      shift_q    <= '0;
      rem_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      valid_q    <= valid_d;
      timer_q    <= timer_d;
      shift_q    <= shift_d;
      rem_q      <= rem_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    timer_d   = timer_q;
    shift_d   = shift_q;
    rem_d     = rem_q;
    tx_data_d = tx_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (rx_fire && (rx_tdata == OP_READ || rx_tdata == OP_WRITE)) begin
          state_d = S_ADDR;
          is_wr_d = (rx_tdata == OP_WRITE);
          cnt_d   = '0;
          wdata_d = '0;
        end
      end

      // The address register doubles as the bus addr field; it only
      // matters to the slave once valid rises.
      S_ADDR: begin
        if (rx_fire) begin
          addr_d = {addr_q[23:0], rx_tdata};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (is_wr_q) begin
              state_d = S_DATA;
            end else begin
              state_d = S_BUS;
              wstrb_d = '0;
              timer_d = '0;
            end
          end
        end
      end

      S_DATA: begin
        if (rx_fire) begin
          wdata_d = {wdata_q[23:0], rx_tdata};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_BUS;
            wstrb_d = '1;
            timer_d = '0;
          end
        end
      end

      // Ready is checked before the timeout so a ready arriving on the
      // expiry edge still completes the transaction.
      S_BUS: begin
        if (mem_ready) begin
          state_d   = S_RESP;
          tx_data_d = ST_ACK;
          shift_d   = mem_rdata;
          rem_d     = is_wr_q ? 3'd0 : 3'd4;
        end else if (timer_inc == TMO) begin
          state_d   = S_RESP;
          tx_data_d = ST_NAK;
          shift_d   = '1;
          rem_d     = is_wr_q ? 3'd0 : 3'd4;
        end else begin
          timer_d = timer_inc;
        end
      end

      S_RESP: begin
        if (tx_fire) begin
          if (rem_q == 3'd0) begin
            state_d = S_IDLE;
          end else begin
            tx_data_d = shift_q[31:24];
            shift_d   = {shift_q[23:0], 8'h00};
            rem_d     = rem_q - 3'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Handshake/strobe outputs follow the next state directly so each one
    // changes on the same edge as the state transition that implies it.
    rx_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
    valid_d    = (state_d == S_BUS);
    tx_valid_d = (state_d == S_RESP);
    busy_d     = (state_d != S_IDLE);
  end

  mpack u_mpack (
    .addr           (addr_q),
    .valid          (valid_q),
    .wstrb          (wstrb_q),
    .wdata          (wdata_q),
    .mem_packed_fwd (mem_packed_fwd),
    .mem_packed_ret (mem_packed_ret),
    .ready          (mem_ready),
    .rdata          (mem_rdata)
  );

  assign rx_tready = rx_ready_q;
  assign tx_tdata  = tx_data_q;
  assign tx_tvalid = tx_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_bus_master.sv
module tb_uart_bus_master;

  localparam int unsigned TMO = 8;
  localparam logic [7:0] R = 8'h52;
  localparam logic [7:0] W = 8'h57;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_tdata = 8'h00;
  logic        rx_tvalid = 1'b0;
  logic        rx_tready;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid;
  logic        tx_tready;
  logic [68:0] fwd;
  logic [32:0] ret;
  logic        busy;

  always #5 clk = ~clk;

  uart_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_tdata       (rx_tdata),
    .rx_tvalid      (rx_tvalid),
    .rx_tready      (rx_tready),
    .tx_tdata       (tx_tdata),
    .tx_tvalid      (tx_tvalid),
    .tx_tready      (tx_tready),
    .mem_packed_fwd (fwd),
    .mem_packed_ret (ret),
    .busy           (busy)
  );

  // Bus field view, taken from the documented layout
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  assign mem_addr  = fwd[31:0];
  assign mem_valid = fwd[32];
  assign mem_wstrb = fwd[36:33];
  assign mem_wdata = fwd[68:37];

  // Responder: slaves live at 0x01xxxxxx and answer after rsp_wait idle cycles
  int unsigned rsp_wait = 0;
  logic [31:0] rsp_data = 32'h0;
  int unsigned rsp_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_cnt <= 0;
    else if (mem_valid && !mem_ready) rsp_cnt <= rsp_cnt + 1;
    else rsp_cnt <= 0;
  end
  assign mem_ready = mem_valid && (mem_addr[31:24] == 8'h01) && (rsp_cnt == rsp_wait);
  assign mem_rdata = mem_ready ? rsp_data : 32'hBAD0_BAD0;
  assign ret = {mem_ready, mem_rdata};

  // Bus monitor (monotonic counters; the main block compares deltas)
  logic        prev_valid = 1'b0;
  int unsigned vcount = 0;
  logic [31:0] cap_addr = 0, cap_wdata = 0;
  logic [3:0]  cap_wstrb = 0;
  int unsigned bus_unstable = 0;
  int unsigned rx_viol = 0;
  always @(negedge clk) begin
    if (mem_valid) begin
      if (!prev_valid) begin
        vcount    <= 1;
        cap_addr  <= mem_addr;
        cap_wdata <= mem_wdata;
        cap_wstrb <= mem_wstrb;
      end else begin
        vcount <= vcount + 1;
        if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_wstrb !== cap_wstrb)
          bus_unstable <= bus_unstable + 1;
      end
    end
    if (rx_tready && (mem_valid || tx_tvalid)) rx_viol <= rx_viol + 1;
    prev_valid <= mem_valid;
  end

  // TX sink: stalls stall_n cycles before each byte, records accepted bytes
  logic [7:0]  rxq[$];
  int unsigned stall_n = 0;
  int unsigned tx_unstable = 0;
  initial begin
    logic       pend;
    logic [7:0] pdata;
    int unsigned sc;
    tx_tready = 1'b0;
    pend = 1'b0;
    pdata = 8'h00;
    sc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_tready = 1'b0;
        pend = 1'b0;
        sc = 0;
      end else begin
        if (pend && (!tx_tvalid || tx_tdata !== pdata)) tx_unstable++;
        tx_tready = tx_tvalid && (sc >= stall_n);
        if (tx_tvalid && tx_tready) begin
          rxq.push_back(tx_tdata);
          sc = 0;
          pend = 1'b0;
        end else if (tx_tvalid) begin
          sc++;
          pend = 1'b1;
          pdata = tx_tdata;
        end else begin
          pend = 1'b0;
        end
      end
    end
  end

  int checks = 0;
  int failures = 0;
  logic [7:0] expq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_tdata  = b;
    rx_tvalid = 1'b1;
    while (!rx_tready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rx_accept", 32'(rx_tready), 32'd1);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    send_byte(op);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    if (op == W) for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask

  // Reference: response bytes from the protocol rules
  task automatic model_resp(input logic [7:0] op, input logic ok, input logic [31:0] rd);
    if (op == W) begin
      expq.push_back(ok ? 8'h06 : 8'h15);
    end else begin
      expq.push_back(ok ? 8'h06 : 8'h15);
      for (int i = 3; i >= 0; i--) expq.push_back(ok ? rd[i*8 +: 8] : 8'hFF);
    end
  endtask

  task automatic check_bytes(input int base, input string tag);
    int n = 0;
    while (rxq.size() < base + expq.size() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_len"}, 32'(rxq.size() - base), 32'(expq.size()));
    for (int i = 0; i < expq.size() && base + i < rxq.size(); i++)
      check({tag, "_byte"}, 32'(rxq[base + i]), 32'(expq[i]));
    check({tag, "_idle_txv"}, 32'(tx_tvalid), 32'd0);
    check({tag, "_idle_rxr"}, 32'(rx_tready), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic run_txn(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int unsigned wt, input int unsigned st);
    int base;
    int unsigned bu, tu;
    logic ok;
    base = rxq.size();
    bu = bus_unstable;
    tu = tx_unstable;
    rsp_wait = wt;
    rsp_data = rd;
    stall_n  = st;
    expq.delete();
    ok = (a[31:24] == 8'h01) && (wt < TMO);
    model_resp(op, ok, rd);
    send_cmd(op, a, wd);
    @(negedge clk);
    rx_tvalid = 1'b0;
    check({tag, "_valid_rise"}, 32'(mem_valid), 32'd1);
    check({tag, "_rxr_fall"}, 32'(rx_tready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check_bytes(base, tag);
    check({tag, "_vcycles"}, vcount, ok ? wt + 1 : TMO);
    check({tag, "_addr"}, cap_addr, a);
    check({tag, "_wstrb"}, 32'(cap_wstrb), (op == W) ? 32'hF : 32'h0);
    if (op == W) check({tag, "_wdata"}, cap_wdata, wd);
    check({tag, "_bus_stable"}, bus_unstable - bu, 32'd0);
    check({tag, "_tx_stable"}, tx_unstable - tu, 32'd0);
  endtask

  initial begin
    int base;
    int unsigned rv;
    logic [7:0]  op, junk;
    logic [31:0] a, d, rd;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_fwd_lo", fwd[31:0], 32'h0);
    check("rst_fwd_hi", {fwd[68:37]}, 32'h0);
    check("rst_fwd_mid", 32'(fwd[36:32]), 32'h0);
    check("rst_txv", 32'(tx_tvalid), 32'd0);
    check("rst_txd", 32'(tx_tdata), 32'd0);
    check("rst_rxr", 32'(rx_tready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rxr_after_rst", 32'(rx_tready), 32'd1);

    run_txn("wr", W, 32'h0100_0004, 32'hDEAD_BEEF, 32'h0, 2, 0);
    run_txn("rd", R, 32'h0100_0004, 32'h0, 32'h0000_0003, 3, 0);
    run_txn("rd_unmapped", R, 32'h7F00_0000, 32'h0, 32'h1234_5678, 0, 0);
    run_txn("wr_unmapped", W, 32'h7F00_0010, 32'h0BAD_F00D, 32'h0, 0, 1);

    // Junk bytes are swallowed without any response
    base = rxq.size();
    send_byte(8'h00);
    send_byte(8'h41);
    @(negedge clk);
    rx_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("junk_no_resp", 32'(rxq.size() - base), 32'd0);
    check("junk_not_busy", 32'(busy), 32'd0);
    run_txn("rd_stall", R, 32'h0100_0013, 32'h0, 32'hA5C3_1E7F, 1, 5);

    // Ready on the expiry edge wins; one cycle later it is a timeout
    run_txn("rd_edge_ok", R, 32'h0100_0008, 32'h0, 32'h8000_0001, TMO - 1, 0);
    run_txn("rd_edge_to", R, 32'h0100_0008, 32'h0, 32'h8000_0001, TMO, 0);
    run_txn("wr_edge_ok", W, 32'h0100_000C, 32'hCAFE_0001, 32'h0, TMO - 1, 2);

    // Back-to-back commands with rx_tvalid held high throughout
    base = rxq.size();
    rv = rx_viol;
    rsp_wait = 1;
    rsp_data = 32'h1122_3344;
    stall_n = 2;
    expq.delete();
    model_resp(R, 1'b1, 32'h1122_3344);
    model_resp(W, 1'b1, 32'h0);
    send_cmd(R, 32'h0100_0020, 32'h0);
    send_cmd(W, 32'h0100_0024, 32'h5566_7788);
    @(negedge clk);
    rx_tvalid = 1'b0;
    check_bytes(base, "b2b");
    check("b2b_rxr_held_low", rx_viol - rv, 32'd0);
    check("b2b_wr_addr", cap_addr, 32'h0100_0024);
    check("b2b_wr_data", cap_wdata, 32'h5566_7788);

    // Reset during BUS aborts asynchronously
    base = rxq.size();
    stall_n = 0;
    send_cmd(R, 32'h7F00_0000, 32'h0);
    @(negedge clk);
    rx_tvalid = 1'b0;
    check("rstbus_valid_before", 32'(mem_valid), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstbus_valid_async", 32'(mem_valid), 32'd0);
    check("rstbus_fwd_async", fwd[31:0], 32'h0);
    check("rstbus_txv", 32'(tx_tvalid), 32'd0);
    check("rstbus_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstbus_rxr_after", 32'(rx_tready), 32'd1);
    check("rstbus_no_resp", 32'(rxq.size() - base), 32'd0);
    run_txn("after_rst", R, 32'h0100_0030, 32'h0, 32'h0F0E_0D0C, 0, 0);

    // Randomised traffic against the reference rules
    for (int i = 0; i < 12; i++) begin
      op = ($urandom_range(0, 1) == 1) ? W : R;
      a  = {($urandom_range(0, 3) == 0) ? 8'h7F : 8'h01, 24'($urandom)};
      d  = $urandom;
      rd = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        junk = 8'($urandom);
        if (junk == R || junk == W) junk = 8'hAA;
        send_byte(junk);
      end
      run_txn("rand", op, a, d, rd, $urandom_range(0, TMO + 1), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

Debug bus initiator that turns a byte-stream command protocol into transactions on the packed PicoRV32 memory bus. Sits between a `uart_rx`/`uart_tx` pair and the bus decoder, in place of or beside the CPU. A host can then peek and poke any peripheral, such as the UART, GPIO or SFR blocks, through a serial link. It drives `mem_packed_fwd` and consumes `mem_packed_ret`, so it is the initiator counterpart of the bus peripherals.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum number of cycles `mem_valid` is held without `mem_ready` before the transaction is aborted. Range 1..65535.

Ports:
- `clk` input 1: the single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx_tdata` input 8: command byte from `uart_rx`.
- `rx_tvalid` input 1: command byte valid.
- `rx_tready` output 1: command byte accepted.
- `tx_tdata` output 8: response byte to `uart_tx`.
- `tx_tvalid` output 1: response byte valid.
- `tx_tready` input 1: `uart_tx` ready.
- `mem_packed_fwd` output 69: {wdata[31:0], wstrb[3:0], valid, addr[31:0]}, MSB first.
- `mem_packed_ret` input 33: {ready, rdata[31:0]}.
- `busy` output 1: high from the first opcode byte accepted until the last response byte handshakes.

## Operation
- Command frames:
  - Read: 0x52 ('R'), then addr[31:24], addr[23:16], addr[15:8], addr[7:0].
  - Write: 0x57 ('W'), then the same 4 address bytes, then 4 data bytes, MSB first.
- Any other byte received in IDLE is consumed and discarded, with no response.
- Bus cycle:
  - Read drives wstrb=0.
  - Write drives wstrb=4'hF and wdata.
  - addr is passed unchanged; the low 2 bits are not forced to 0.
- Response frames:
  - Status byte: 0x06 on success, 0x15 on timeout.
  - Read success: status byte, then rdata as 4 bytes, MSB first.
  - Read timeout: 0x15, then 0xFF ×4 (always 5 bytes for a read).
  - Write, either outcome: status byte only.
- FSM states:
  - IDLE: wait for an opcode byte.
  - ADDR: count 4 address bytes; go to DATA if write, BUS if read.
  - DATA: count 4 data bytes, then go to BUS.
  - BUS: drive `mem_valid`; on `mem_ready`, or on timeout, go to RESP.
  - RESP: shift out the response bytes, then return to IDLE.
- Back-pressure:
  - `rx_tready`=1 only in IDLE, ADDR and DATA.
  - Bytes arriving in BUS or RESP stay pending in `uart_rx`; none are dropped by this block.

## Timing
- Reset values: every output is registered and resets to 0. This includes `mem_packed_fwd` (all fields), `tx_tvalid`, `rx_tready` and `busy`. The FSM resets to IDLE.
- `rx_tready` rises on the first clk edge after `rst_n` deasserts.
- Reset mid-operation aborts immediately: `mem_valid` and `tx_tvalid` drop asynchronously, and no partial frame survives.
- One byte is accepted per cycle when `rx_tvalid`&&`rx_tready`.
- `rx_tready` falls in the cycle after the last command byte is accepted.
- `mem_valid`, addr, wdata and wstrb assert in the same cycle that `rx_tready` falls, which is 1 cycle after the last byte is accepted.
- All bus fields are held stable while `mem_valid`=1.
- `mem_ready`=1 is sampled on an edge with `mem_valid`=1:
  - rdata is captured on that edge.
  - `mem_valid` is 0 in the next cycle.
  - The first response byte is presented with `tx_tvalid`=1 in that same next cycle.
  - The master never holds `mem_valid` for a second cycle after ready, which is what the peripherals' one-cycle `ready_` lockout expects.
- `mem_ready` is ignored when `mem_valid`=0.
- Timeout:
  - A 16-bit counter clears when `mem_valid` rises and increments each cycle `mem_valid`=1 without ready.
  - When the counter equals `TIMEOUT_CYCLES`, `mem_valid` drops and RESP carries status 0x15.
  - If `mem_ready` arrives on the expiry edge, ready wins and the transaction succeeds.
- TX handshake:
  - `tx_tdata` is stable while `tx_tvalid`=1 && !`tx_tready`.
  - After a handshake the next byte is presented in the following cycle, with no bubble.
  - After the final handshake, `tx_tvalid` drops and the FSM is in IDLE the next cycle, with `rx_tready`=1.
- Minimum latency for a write: 9 byte-accept cycles + 1 + the bus wait + 1 response byte.

## Structure
- Shared package holds:
  - opcode constants OP_READ=8'h52 and OP_WRITE=8'h57;
  - status constants ST_ACK=8'h06 and ST_NAK=8'h15;
  - the FSM state enum;
  - the packed-bus field offsets, also used by `munpack`.
- Sub-module: instantiate the existing `mpack` to build `mem_packed_fwd` and split `mem_packed_ret`. The FSM itself is in the top module.

## Test plan
- Write, 0x57 01 00 00 04 DE AD BE EF, against a `uart_pack` model at BASE 8'h01:
  - `mem_valid` with addr=0x01000004, wstrb=F, wdata=0xDEADBEEF;
  - then the response 0x06.
- Read, 0x52 01 00 00 04, with the responder returning rdata=0x00000003 after a 3-cycle wait:
  - response 06 00 00 00 03;
  - `mem_valid` high for exactly 4 cycles.
- Read of an unmapped address 0x7F000000, with no ready and `TIMEOUT_CYCLES`=8:
  - `mem_valid` drops after 8 cycles;
  - response 15 FF FF FF FF.
- Junk 0x00 0x41, then a valid read: junk consumed silently and the read completes normally. With `tx_tready` held low for 5 cycles per byte, the response bytes are unchanged and `tx_tdata` is stable while stalled.
- Back-to-back commands with `rx_tvalid` held high: `rx_tready` is 0 throughout BUS and RESP, and no byte is lost. Ready coinciding with the timeout edge gives status 0x06.
- Pull `rst_n` low during BUS: `mem_valid`=0 immediately. After release the FSM is in IDLE and the next command works.
